// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative 32x32 multiply / divide sequencer (IDLE -> RUN -> DONE)
// Ports: clock, reset (sync, active-high); start/op/a/b request (op 00 MULTU, 01 MULT,
//        10 DIVU, 11 DIV); busy (RUN), done (DONE pulse), hi/lo result, div_by_zero.
// Define MULDIV_SEQUENCER_DIV_EN to build the divider; without it divide ops complete
// immediately leaving hi/lo untouched.
module muldiv_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_by_zero
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [5:0] cnt;
   logic [31:0] m, a_mag, b_mag;
   logic [63:0] acc, acc_nx, prod, res;
   logic [32:0] msum;
   logic accept, direct, last, sa, sb, neg_res;
`ifdef MULDIV_SEQUENCER_DIV_EN
   logic dv, neg_rem;
   logic [32:0] trial;
`endif
   always_comb begin
      accept = start && state != RUN;
      sa = op[0] & a[31];
      sb = op[0] & b[31];
      a_mag = sa ? -a : a;
      b_mag = sb ? -b : b;
`ifdef MULDIV_SEQUENCER_DIV_EN
      direct = op[1] && b == 32'd0;
`else
      direct = op[1];
`endif
      last = cnt == 6'd31;
      // multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
      msum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
      acc_nx = {msum, acc[31:1]};
`ifdef MULDIV_SEQUENCER_DIV_EN
      // restoring divide: acc = {remainder, dividend/quotient}, shifted left each step
      trial = {1'b0, acc[62:31]} - {1'b0, m};
      if (dv) acc_nx = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
`endif
      prod = neg_res ? -acc_nx : acc_nx;
`ifdef MULDIV_SEQUENCER_DIV_EN
      res = dv ? {neg_rem ? -acc_nx[63:32] : acc_nx[63:32], neg_res ? -acc_nx[31:0] : acc_nx[31:0]} : prod;
`else
      res = prod;
`endif
      state_nx = accept ? (direct ? DONE : RUN) : state == RUN ? (last ? DONE : RUN) : IDLE;
      busy = state == RUN;
      done = state == DONE;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         hi <= '0;
         lo <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cnt <= '0;
            m <= op[1] ? b_mag : a_mag;
            acc <= {32'd0, op[1] ? a_mag : b_mag};
            neg_res <= sa ^ sb;
`ifdef MULDIV_SEQUENCER_DIV_EN
            dv <= op[1];
            neg_rem <= sa;
            if (direct) begin
               hi <= a;
               lo <= '1;
               div_by_zero <= 1'b1;
            end
`else
            if (direct) div_by_zero <= 1'b0;
`endif
         end else if (busy) begin
            acc <= acc_nx;
            cnt <= cnt + 6'd1;
            if (last) begin
               {hi, lo} <= res;
               div_by_zero <= 1'b0;
            end
         end
      end
   end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request pulse; sampled on a rising edge of clock.
REQ-004 SHALL have port: op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
REQ-005 SHALL have port: a  input  32  multiplicand/dividend; sampled with start.
REQ-006 SHALL have port: b  input  32  multiplier/divisor; sampled with start.
REQ-007 SHALL have port: busy  output  1  high while an operation iterates.
REQ-008 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port: hi  output  32  product upper word / remainder.
REQ-010 SHALL have port: lo  output  32  product lower word / quotient.
REQ-011 SHALL have port: div_by_zero  output  1  valid with done; high when a divide had b==0.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE or DONE (back-to-back accepted); start in RUN SHALL be ignored, operands and op unaffected.
REQ-014 On accept, SHALL latch op, |a|, |b| (magnitudes for signed ops, raw values for unsigned), the result sign, and the remainder sign, then enter RUN.
REQ-015 Multiply SHALL use 32 radix-2 shift-add iterations on a 64-bit accumulator, one iteration per cycle.
REQ-016 Divide SHALL use 32 restoring shift-subtract iterations, one per cycle; quotient in lo, remainder in hi.
REQ-017 Signed multiply: 64-bit result SHALL be negated iff sign(a) XOR sign(b).
REQ-018 Signed divide: quotient SHALL be negated iff sign(a) XOR sign(b); remainder SHALL take sign of a; results truncated to 32 bits (0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0).
REQ-019 An iteration counter (6 bits) SHALL count 0..31; after the 32nd iteration the FSM SHALL enter DONE.
REQ-020 Latency: done SHALL assert exactly 33 clock edges after the accepting edge (32 RUN cycles + DONE).
REQ-021 busy SHALL be high exactly in RUN; done SHALL be high exactly in DONE; DONE SHALL return to IDLE unless start is accepted there.
REQ-022 hi/lo SHALL update only on the edge entering DONE and hold until the next entry to DONE.
REQ-023 DIVU/DIV with b==0 SHALL skip RUN: DONE on the next edge, hi=a, lo=0xFFFFFFFF, div_by_zero=1.
REQ-024 div_by_zero SHALL be 0 for all multiplies and nonzero divides, updated with hi/lo.

Reset
REQ-025 reset SHALL force state IDLE, counter 0, busy=0, done=0, hi=0, lo=0, div_by_zero=0 on the next edge.
REQ-026 reset SHALL take priority over start and over any in-progress iteration; an aborted operation SHALL never produce done.

Configuration
REQ-027 Macro MULDIV_SEQUENCER_DIV_EN SHALL compile in the divider datapath (REQ-016, REQ-018, REQ-023).
REQ-028 Without MULDIV_SEQUENCER_DIV_EN, op 10/11 SHALL be accepted, go to DONE on the next edge, leave hi/lo unchanged, and set div_by_zero=0; multiply behaviour SHALL be identical.

Verification
REQ-029 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 33 edges after start, hi=0xFFFFFFFE, lo=0x00000001, busy high 32 cycles.
REQ-030 MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
REQ-031 DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
REQ-032 DIVU a=7 b=0 -> done on 2nd edge, busy never high, hi=7, lo=0xFFFFFFFF, div_by_zero=1.
REQ-033 Start during RUN with different operands -> ignored, original result delivered; start in DONE cycle -> new op accepted, second done 33 edges later.
REQ-034 reset asserted 10 cycles into RUN -> next edge busy=0, hi=lo=0, no done pulse; fresh MULTU 3*4 afterwards -> lo=12, hi=0.
